// File: rtl/uartb_frame_rx_pkg.sv
// uartb_pkg: shared types and constants for the UARTB receive framing stage.
//   frame_state_e : framing FSM states (IDLE, LEN, PAYLOAD, CSUM)
//   SOF_DEFAULT   : default start-of-frame marker byte
//   csum_add      : modulo-256 checksum accumulation
package uartb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } frame_state_e;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;

    // Frame checksum is a plain byte sum; a valid frame sums to zero.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uartb_frame_rx_if.sv
// uartb_frame_rx_if: byte-stream input and committed-payload read side of the
// UARTB receive framing stage.
//   rx_data/rx_stb : received byte and its one-cycle strobe
//   rd             : pop the payload FIFO head
//   dout/empty/count : show-ahead FIFO head, empty flag, committed byte count
//   frame_ok/frame_err : one-cycle frame outcome pulses
//   err_count      : saturating discarded-frame counter
// master modport drives the byte stream and rd; slave modport is the framer.
interface uartb_frame_rx_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    rx_data;
    logic          rx_stb;
    logic          rd;
    logic [7:0]    dout;
    logic          empty;
    logic [CW-1:0] count;
    logic          frame_ok;
    logic          frame_err;
    logic [7:0]    err_count;

    modport master (
        output rx_data, rx_stb, rd,
        input  dout, empty, count, frame_ok, frame_err, err_count
    );

    modport slave (
        input  rx_data, rx_stb, rd,
        output dout, empty, count, frame_ok, frame_err, err_count
    );
endinterface

// File: rtl/uartb_frame_rx_fifo.sv
// uartb_rollback_fifo: payload FIFO whose write side is speculative until
// committed. Bytes pushed after the last commit are invisible to the reader and
// can be discarded by rolling wr_ptr back to the position marked at frame start.
//   clk, reset : clock, synchronous active-high reset
//   push/push_data : write one byte at wr_ptr
//   mark       : remember wr_ptr as the start of the current frame
//   commit     : publish everything written so far to the reader
//   rollback   : discard bytes written since the last mark
//   pop        : advance the read pointer (ignored when nothing committed)
//   dout       : show-ahead head byte; count : committed unread bytes
//   full       : written-but-unread bytes (committed or not) equals DEPTH
module uartb_rollback_fifo #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          mark,
    input  logic          commit,
    input  logic          rollback,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [PW-1:0] count,
    output logic          full
);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] wr_commit_r;
    logic [PW-1:0] wr_start_r;

    // Payload storage; no reset needed, readers only see committed entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Pointer bookkeeping; the extra MSB distinguishes full from empty on wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r    <= {PW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            wr_commit_r <= {PW{1'b0}};
            wr_start_r  <= {PW{1'b0}};
        end else begin
            if (rollback) begin
                wr_ptr_r <= wr_start_r;
            end else if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (mark) begin
                wr_start_r <= wr_ptr_r;
            end
            if (commit) begin
                wr_commit_r <= wr_ptr_r;
            end
            if (pop && (count != {PW{1'b0}})) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign count = wr_commit_r - rd_ptr_r;
    assign full  = ((wr_ptr_r - rd_ptr_r) == DEPTH_C);
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/uartb_frame_rx.sv
// uartb_frame_rx: receive framing stage behind the UARTB receiver. Hunts for
// SOF, parses LEN, payload and a zero-sum checksum byte; payload becomes
// readable only once the checksum passes, otherwise it is rolled back.
//   clk, reset : clock, synchronous active-high reset
//   bus        : uartb_frame_rx_if.slave (byte stream in, FIFO read side out)
// Optional build macro UARTB_FRAME_TIMEOUT_EN adds an inter-byte timeout of
// TIMEOUT cycles that aborts a stalled frame.
module uartb_frame_rx
    import uartb_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int         MAXLEN  = 16,
    parameter int         TIMEOUT = 2500
) (
    input  logic                  clk,
    input  logic                  reset,
    uartb_frame_rx_if.slave       bus
);
    localparam int         CW       = $clog2(DEPTH) + 1;
    localparam logic [8:0] MAXLEN_C = 9'(MAXLEN);

    frame_state_e  state_r, state_s;
    logic [7:0]    remaining_r, remaining_s;
    logic [7:0]    sum_r, sum_s;
    logic          push_s, mark_s, commit_s, rollback_s, ok_s, err_s;
    logic          pop_s, full_s, empty_s, tmo_hit_s;
    logic [CW-1:0] count_s;
    logic          frame_ok_r, frame_err_r;
    logic [7:0]    err_count_r;

    uartb_rollback_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (bus.rx_data),
        .mark      (mark_s),
        .commit    (commit_s),
        .rollback  (rollback_s),
        .pop       (pop_s),
        .dout      (bus.dout),
        .count     (count_s),
        .full      (full_s)
    );

`ifdef UARTB_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_r;

    // Inter-byte timer: restarts on every byte, idles at zero outside a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_r <= {TW{1'b0}};
        end else if (bus.rx_stb || (state_r == ST_IDLE)) begin
            tmo_r <= {TW{1'b0}};
        end else if (tmo_r != TW'(TIMEOUT)) begin
            tmo_r <= tmo_r + TW'(1);
        end
    end

    assign tmo_hit_s = (state_r != ST_IDLE) && (tmo_r == TW'(TIMEOUT));
`else
    assign tmo_hit_s = 1'b0;
`endif

    assign empty_s = (count_s == {CW{1'b0}});
    assign pop_s   = bus.rd & ~empty_s;

    // Framer state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            remaining_r <= 8'd0;
            sum_r       <= 8'd0;
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
            sum_r       <= sum_s;
        end
    end

    // Next-state decode and FIFO control for each received byte.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        sum_s       = sum_r;
        push_s      = 1'b0;
        mark_s      = 1'b0;
        commit_s    = 1'b0;
        rollback_s  = 1'b0;
        ok_s        = 1'b0;
        err_s       = 1'b0;
        if (tmo_hit_s) begin
            // Nothing has been written yet while in LEN, so only later states
            // need the write pointer restored.
            err_s      = 1'b1;
            rollback_s = (state_r == ST_PAYLOAD) || (state_r == ST_CSUM);
            state_s    = ST_IDLE;
        end else if (bus.rx_stb) begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.rx_data == SOF) begin
                        state_s = ST_LEN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LEN: begin
                    sum_s = bus.rx_data;
                    if ((bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > MAXLEN_C)) begin
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        mark_s      = 1'b1;
                        remaining_s = bus.rx_data;
                        state_s     = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (full_s) begin
                        rollback_s = 1'b1;
                        err_s      = 1'b1;
                        state_s    = ST_IDLE;
                    end else begin
                        push_s      = 1'b1;
                        sum_s       = csum_add(sum_r, bus.rx_data);
                        remaining_s = remaining_r - 8'd1;
                        if (remaining_r == 8'd1) begin
                            state_s = ST_CSUM;
                        end else begin
                            state_s = ST_PAYLOAD;
                        end
                    end
                end
                ST_CSUM: begin
                    state_s = ST_IDLE;
                    if (csum_add(sum_r, bus.rx_data) == 8'd0) begin
                        commit_s = 1'b1;
                        ok_s     = 1'b1;
                    end else begin
                        rollback_s = 1'b1;
                        err_s      = 1'b1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Outcome pulses and the saturating discarded-frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            err_count_r <= 8'd0;
        end else begin
            frame_ok_r  <= ok_s;
            frame_err_r <= err_s;
            if (err_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end
        end
    end

    assign bus.count     = count_s;
    assign bus.empty     = empty_s;
    assign bus.frame_ok  = frame_ok_r;
    assign bus.frame_err = frame_err_r;
    assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_uartb_frame_rx.sv
// Self-checking bench for uartb_frame_rx. A frame-level reference model (a
// queue of committed payload bytes plus outcome rules) predicts frame events
// and read data into scoreboard queues; a monitor compares DUT outputs.
module tb_uartb_frame_rx;
    localparam int         DEPTH   = 16;
    localparam int         MAXLEN  = 16;
    localparam int         TIMEOUT = 2500;
    localparam logic [7:0] SOF     = 8'h7E;
    localparam int         EV_OK   = 1;
    localparam int         EV_ERR  = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uartb_frame_rx_if #(.DEPTH(DEPTH)) bus();

    uartb_frame_rx #(.DEPTH(DEPTH), .SOF(SOF), .MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_errs = 0;
    logic [7:0] model_q[$];
    logic [7:0] exp_rd_q[$];
    int         exp_evt_q[$];
    logic [7:0] pl_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_unexpected(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents output.
    initial begin
        logic [31:0] ev;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.rd && !bus.empty) begin
                    if (exp_rd_q.size() == 0) report_unexpected("pop_data", 32'(bus.dout));
                    else chk("pop_data", 32'(bus.dout), 32'(exp_rd_q.pop_front()));
                end
                if (bus.frame_ok || bus.frame_err) begin
                    ev = {30'd0, bus.frame_err, bus.frame_ok};
                    if (exp_evt_q.size() == 0) report_unexpected("frame_event", ev);
                    else chk("frame_event", ev, 32'(exp_evt_q.pop_front()));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_rd);
        bus.rx_data = b;
        bus.rx_stb  = 1'b1;
        bus.rd      = with_rd;
        @(posedge clk);
        #1;
        bus.rx_stb  = 1'b0;
        bus.rd      = 1'b0;
    endtask

    function automatic void expect_err();
        exp_evt_q.push_back(EV_ERR);
        if (exp_errs < 255) exp_errs++;
    endfunction

    function automatic logic [7:0] good_csum(input logic [7:0] len);
        logic [7:0] s;
        s = len;
        foreach (pl_q[i]) s = s + pl_q[i];
        return 8'd0 - s;
    endfunction

    // Sends a frame using pl_q as payload and predicts its outcome from the
    // framing rules; an aborted frame is cut off at the byte that aborts it.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] csum, input bit rd_last);
        int occ;
        logic [7:0] s;
        send_byte(SOF, 1'b0);
        send_byte(len, 1'b0);
        if (len == 8'd0 || int'(len) > MAXLEN) begin
            expect_err();
            return;
        end
        occ = model_q.size();
        if (occ + int'(len) > DEPTH) begin
            for (int i = 0; i <= DEPTH - occ; i++) send_byte(pl_q[i], 1'b0);
            expect_err();
            return;
        end
        s = len;
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pl_q[i], 1'b0);
            s = s + pl_q[i];
        end
        if (rd_last) exp_rd_q.push_back(model_q.pop_front());
        send_byte(csum, rd_last);
        if (8'(s + csum) == 8'd0) begin
            exp_evt_q.push_back(EV_OK);
            for (int i = 0; i < int'(len); i++) model_q.push_back(pl_q[i]);
        end else begin
            expect_err();
        end
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            exp_rd_q.push_back(model_q.pop_front());
            bus.rd = 1'b1;
            @(posedge clk);
            #1;
            bus.rd = 1'b0;
        end
    endtask

    task automatic rand_payload(input int n);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
    endtask

    task automatic check_state(input string tag);
        idle(2);
        chk({tag, "_count"}, 32'(bus.count), 32'(model_q.size()));
        chk({tag, "_empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
        chk({tag, "_err_count"}, 32'(bus.err_count), 32'(exp_errs));
        chk({tag, "_pending_events"}, 32'(exp_evt_q.size()), 32'd0);
    endtask

    initial begin
        int r;
        logic [7:0] len, cs, junk;
        bus.rx_data = 8'd0;
        bus.rx_stb  = 1'b0;
        bus.rd      = 1'b0;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        chk("reset_count", 32'(bus.count), 32'd0);
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_frame_ok", 32'(bus.frame_ok), 32'd0);
        chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
        chk("reset_err_count", 32'(bus.err_count), 32'd0);

        // Good frame 7E 03 11 22 33 97.
        pl_q = {8'h11, 8'h22, 8'h33};
        send_frame(8'h03, 8'h97, 1'b0);
        check_state("good");
        chk("good_head", 32'(bus.dout), 32'h11);
        pop_n(3);
        check_state("good_drain");

        // Bad checksum, then a good one-byte frame.
        pl_q = {8'hAA, 8'hBB};
        send_frame(8'h02, 8'h00, 1'b0);
        check_state("bad_csum");
        pl_q = {8'h55};
        send_frame(8'h01, good_csum(8'h01), 1'b0);
        check_state("after_bad");
        pop_n(1);

        // Illegal lengths.
        pl_q.delete();
        send_frame(8'h00, 8'h00, 1'b0);
        check_state("len_zero");
        send_frame(8'h11, 8'h00, 1'b0);
        check_state("len_big");

        // Overflow: 15 committed bytes, then a 2-byte frame.
        rand_payload(15);
        send_frame(8'd15, good_csum(8'd15), 1'b0);
        check_state("ovf_fill");
        rand_payload(2);
        send_frame(8'd2, good_csum(8'd2), 1'b0);
        check_state("ovf");
        pop_n(15);
        check_state("ovf_drain");

        // Pop and commit on the same edge at count=1.
        rand_payload(1);
        send_frame(8'd1, good_csum(8'd1), 1'b0);
        rand_payload(1);
        send_frame(8'd1, good_csum(8'd1), 1'b1);
        check_state("simul");
        chk("simul_dout", 32'(bus.dout), 32'(model_q[0]));
        pop_n(1);

`ifdef UARTB_FRAME_TIMEOUT_EN
        send_byte(SOF, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0);
        expect_err();
        idle(TIMEOUT + 3);
        check_state("timeout");
        rand_payload(2);
        send_frame(8'd2, good_csum(8'd2), 1'b0);
        check_state("after_timeout");
`endif

        // Reset in the middle of a frame wipes committed data and the counter.
        rand_payload(3);
        send_frame(8'd3, good_csum(8'd3), 1'b0);
        send_byte(SOF, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h12, 1'b0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        model_q.delete();
        exp_errs = 0;
        check_state("midreset");
        rand_payload(2);
        send_frame(8'd2, good_csum(8'd2), 1'b0);
        check_state("after_reset");

        // Randomized frames with junk between them.
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == SOF) junk = 8'h00;
                send_byte(junk, 1'b0);
            end
            if (model_q.size() > DEPTH / 2) pop_n($urandom_range(1, model_q.size()));
            r = $urandom_range(0, 9);
            if (r == 0) len = 8'd0;
            else if (r == 1) len = 8'($urandom_range(MAXLEN + 1, 255));
            else len = 8'($urandom_range(1, MAXLEN));
            if (len == 8'd0 || int'(len) > MAXLEN) pl_q.delete();
            else rand_payload(int'(len));
            cs = good_csum(len);
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            send_frame(len, cs, (model_q.size() > 0) && ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) check_state("rand");
        end
        check_state("rand_end");
        pop_n(model_q.size());
        check_state("final");

        for (int i = 0; i < 20 && (exp_rd_q.size() != 0 || exp_evt_q.size() != 0); i++) idle(1);
        chk("drain_reads", 32'(exp_rd_q.size()), 32'd0);
        chk("drain_events", 32'(exp_evt_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
